// File: rtl/median_line_stacker_if.sv
// Stream, frame-control and column-output signals between a pixel source,
// the line stacker and the median core.
interface median_line_stacker_if #(
  parameter int unsigned SIZE = 3,
  parameter int unsigned DW   = 14
);
  logic                 start;
  logic [15:0]          iw;
  logic [15:0]          ih;
  logic [DW-1:0]        din;
  logic                 din_valid;
  logic                 din_ready;
  logic [SIZE*DW-1:0]   stack_data;
  logic                 valid;
  logic [15:0]          sent_line_cntr;
  logic [15:0]          sent_pix_cntr;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output start, iw, ih, din, din_valid,
    input  din_ready, stack_data, valid, sent_line_cntr, sent_pix_cntr, busy, frame_done
  );

  modport slave (
    input  start, iw, ih, din, din_valid,
    output din_ready, stack_data, valid, sent_line_cntr, sent_pix_cntr, busy, frame_done
  );
endinterface

// File: rtl/median_line_stacker.sv
// Buffers raster lines in a ring of SIZE+1 line memories and emits one SIZE-tall column per
// image pixel, each output row as a gap-free burst of iw columns.
module median_line_stacker #(
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DW    = 14,
  parameter int unsigned MAX_W = 1024,
  parameter int unsigned AW    = 10
) (
  input logic                   clk,
  input logic                   rstb,
  median_line_stacker_if.slave  bus
);

  localparam int unsigned H  = SIZE / 2;
  localparam int unsigned NB = SIZE + 1;
  localparam int unsigned BW = $clog2(NB);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [15:0]        iw_q, iw_d, ih_q, ih_d;
  logic [15:0]        wr_pix_q, wr_pix_d, wr_line_q, wr_line_d;
  logic [BW-1:0]      wr_bank_q, wr_bank_d;
  logic [15:0]        rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [BW-1:0]      rd_base_q, rd_base_d;

  logic               s1_valid_q, s1_done_q;
  logic [15:0]        s1_row_q, s1_col_q;
  logic [BW-1:0]      s1_base_q;

  logic               valid_q, done_q;
  logic [15:0]        line_q, pix_q;
  logic [SIZE*DW-1:0] stack_q, stack_d;

  logic [DW-1:0]      mem_q [NB][MAX_W];
  logic [DW-1:0]      rd_data_q [NB];

  logic               busy, start_ok, din_ready, wr_en, row_ready;
  logic               last_col, last_row, last_wr_pix;
  logic [16:0]        row_need;

  assign busy      = (state_q == StWait) || (state_q == StEmit);
  assign start_ok  = (state_q == StIdle) && bus.start && (bus.iw != 16'd0) &&
                     (32'(bus.iw) <= MAX_W) && (bus.ih != 16'd0);
  // Never run more than H+1 lines ahead of the emitted rows: the ring then cannot clobber a
  // line that the current output row still reads.
  assign row_need  = {1'b0, rd_row_q} + 17'(H + 1);
  assign din_ready = busy && (wr_line_q < ih_q) && ({1'b0, wr_line_q} <= row_need);
  assign wr_en     = bus.din_valid && din_ready;
  assign row_ready = ({1'b0, wr_line_q} >= row_need) || (wr_line_q >= ih_q);

  assign last_col    = (rd_col_q == iw_q - 16'd1);
  assign last_row    = (rd_row_q == ih_q - 16'd1);
  assign last_wr_pix = (wr_pix_q == iw_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    iw_d      = iw_q;
    ih_d      = ih_q;
    wr_pix_d  = wr_pix_q;
    wr_line_d = wr_line_q;
    wr_bank_d = wr_bank_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    rd_base_d = rd_base_q;

    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d   = StWait;
          iw_d      = bus.iw;
          ih_d      = bus.ih;
          wr_pix_d  = '0;
          wr_line_d = '0;
          wr_bank_d = '0;
          rd_row_d  = '0;
          rd_col_d  = '0;
          rd_base_d = BW'(NB - H);  // bank of row -H, i.e. (-H) mod NB
        end
      end
      StWait: begin
        if (row_ready) state_d = StEmit;
      end
      StEmit: begin
        if (last_col) begin
          rd_col_d = '0;
          if (last_row) begin
            state_d = StDone;
          end else begin
            state_d   = StWait;
            rd_row_d  = rd_row_q + 16'd1;
            rd_base_d = (rd_base_q == BW'(NB - 1)) ? '0 : rd_base_q + BW'(1);
          end
        end else begin
          rd_col_d = rd_col_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      if (last_wr_pix) begin
        wr_pix_d  = '0;
        wr_line_d = wr_line_q + 16'd1;
        wr_bank_d = (wr_bank_q == BW'(NB - 1)) ? '0 : wr_bank_q + BW'(1);
      end else begin
        wr_pix_d = wr_pix_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_en && (wr_bank_q == BW'(b))) mem_q[b][wr_pix_q[AW-1:0]] <= bus.din;
      rd_data_q[b] <= mem_q[b][rd_col_q[AW-1:0]];
    end
  end

  // Slice k shows row r-H+k from bank (base+k) mod NB; rows outside the image read as zero.
  always_comb begin
    int row;
    int bsel;
    stack_d = '0;
    row     = 0;
    bsel    = 0;
    if (s1_valid_q) begin
      for (int unsigned k = 0; k < SIZE; k++) begin
        row  = int'(s1_row_q) + int'(k) - int'(H);
        bsel = int'(s1_base_q) + int'(k);
        if (bsel >= int'(NB)) bsel = bsel - int'(NB);
        if ((row >= 0) && (row < int'(ih_q))) stack_d[(SIZE-1-k)*DW +: DW] = rd_data_q[bsel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= StIdle;
      iw_q       <= '0;
      ih_q       <= '0;
      wr_pix_q   <= '0;
      wr_line_q  <= '0;
      wr_bank_q  <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_base_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_done_q  <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_base_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      line_q     <= '0;
      pix_q      <= '0;
      stack_q    <= '0;
    end else begin
      state_q    <= state_d;
      iw_q       <= iw_d;
      ih_q       <= ih_d;
      wr_pix_q   <= wr_pix_d;
      wr_line_q  <= wr_line_d;
      wr_bank_q  <= wr_bank_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      rd_base_q  <= rd_base_d;
      s1_valid_q <= (state_q == StEmit);
      s1_done_q  <= (state_q == StDone);
      s1_row_q   <= rd_row_q;
      s1_col_q   <= rd_col_q;
      s1_base_q  <= rd_base_q;
      valid_q    <= s1_valid_q;
      done_q     <= s1_done_q;
      stack_q    <= stack_d;
      if (s1_valid_q) begin
        line_q <= s1_row_q;
        pix_q  <= s1_col_q;
      end
    end
  end

  assign bus.din_ready      = din_ready;
  assign bus.stack_data     = stack_q;
  assign bus.valid          = valid_q;
  assign bus.sent_line_cntr = line_q;
  assign bus.sent_pix_cntr  = pix_q;
  assign bus.busy           = busy;
  assign bus.frame_done     = done_q;

endmodule

// File: tb/tb_median_line_stacker.sv
// Scoreboard bench for median_line_stacker: a SIZE=3 instance for most frames and a SIZE=5
// instance for the taller window.
module tb_median_line_stacker;

  typedef struct packed {
    logic [15:0]  r;
    logic [15:0]  c;
    logic [127:0] stk;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  median_line_stacker_if #(.SIZE(3), .DW(14)) bus3 ();
  median_line_stacker_if #(.SIZE(5), .DW(14)) bus5 ();

  median_line_stacker #(.SIZE(3), .DW(14), .MAX_W(1024), .AW(10)) u_dut3 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus3.slave)
  );

  median_line_stacker #(.SIZE(5), .DW(14), .MAX_W(16), .AW(4)) u_dut5 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus5.slave)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [13:0]  img [16][16];
  exp_t         sb3[$];
  exp_t         sb5[$];

  int cur_w = 1, acc3 = 0, rows_out = 0, max_lead = 0, stall3 = 0, v3_cnt = 0, done3_cnt = 0;
  int v5_cnt = 0, done5_cnt = 0;
  bit prev3 = 1'b0, prev5 = 1'b0, abort_flag = 1'b0;
  logic [127:0] cap_a, cap_b, cap_c, cap5;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] exp_stack(input int s, input int r, input int c, input int h);
    logic [127:0] res;
    int row;
    res = '0;
    for (int k = 0; k < s; k++) begin
      row = r - s / 2 + k;
      if (row >= 0 && row < h) res[(s-1-k)*14 +: 14] = img[row][c];
    end
    return res;
  endfunction

  // Output monitor for the SIZE=3 instance.
  always @(negedge clk) begin
    exp_t e;
    int lead;
    if (bus3.valid) begin
      v3_cnt++;
      if (bus3.sent_pix_cntr != 16'd0) check("d3_gap", 128'(prev3), 128'(1));
      check("d3_sb_nonempty", 128'(sb3.size() != 0), 128'(1));
      if (sb3.size() != 0) begin
        e = sb3.pop_front();
        check("d3_line", 128'(bus3.sent_line_cntr), 128'(e.r));
        check("d3_pix", 128'(bus3.sent_pix_cntr), 128'(e.c));
        check("d3_stack", 128'(bus3.stack_data), e.stk);
      end
      if (bus3.sent_line_cntr == 16'd0 && bus3.sent_pix_cntr == 16'd2) cap_a = 128'(bus3.stack_data);
      if (bus3.sent_line_cntr == 16'd1 && bus3.sent_pix_cntr == 16'd0) cap_b = 128'(bus3.stack_data);
      if (bus3.sent_line_cntr == 16'd2 && bus3.sent_pix_cntr == 16'd3) cap_c = 128'(bus3.stack_data);
      if (int'(bus3.sent_pix_cntr) == cur_w - 1) rows_out++;
    end else begin
      check("d3_idle_zero", 128'(bus3.stack_data), 128'(0));
    end
    prev3 = bus3.valid;
    if (bus3.frame_done) begin
      done3_cnt++;
      check("d3_done_after_last", 128'(sb3.size()), 128'(0));
    end
    if (bus3.din_valid && bus3.din_ready) begin
      lead = acc3 / cur_w - rows_out;
      if (lead > max_lead) max_lead = lead;
      acc3++;
    end
    if (bus3.busy && bus3.din_valid && !bus3.din_ready) stall3++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus5.valid) begin
      v5_cnt++;
      if (bus5.sent_pix_cntr != 16'd0) check("d5_gap", 128'(prev5), 128'(1));
      check("d5_sb_nonempty", 128'(sb5.size() != 0), 128'(1));
      if (sb5.size() != 0) begin
        e = sb5.pop_front();
        check("d5_line", 128'(bus5.sent_line_cntr), 128'(e.r));
        check("d5_pix", 128'(bus5.sent_pix_cntr), 128'(e.c));
        check("d5_stack", 128'(bus5.stack_data), e.stk);
      end
      if (bus5.sent_line_cntr == 16'd2 && bus5.sent_pix_cntr == 16'd2) cap5 = 128'(bus5.stack_data);
    end
    prev5 = bus5.valid;
    if (bus5.frame_done) done5_cnt++;
  end

  task automatic run3(input int w, input int h, input int duty, input bit rnd, input bit abort,
                      input bit bogus);
    int idx, cyc, done0, i;
    exp_t e;
    @(posedge clk); #1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        img[y][x] = rnd ? 14'($urandom_range(0, 16383)) : 14'(16 * y + x);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        e.r = 16'(r); e.c = 16'(c); e.stk = exp_stack(3, r, c, h);
        sb3.push_back(e);
      end
    cur_w = w; acc3 = 0; rows_out = 0; max_lead = 0; stall3 = 0; v3_cnt = 0;
    cap_a = '1; cap_b = '1; cap_c = '1; abort_flag = 1'b0;
    done0 = done3_cnt;
    bus3.iw = 16'(w); bus3.ih = 16'(h); bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    idx = 0; cyc = 0;
    bus3.din = img[0][0];
    bus3.din_valid = ($urandom_range(0, 99) < duty);
    fork
      begin
        while (idx < w * h && cyc < 20000 && !abort_flag) begin
          @(negedge clk);
          if (bus3.din_valid && bus3.din_ready) idx++;
          @(posedge clk); #1;
          cyc++;
          // A start pulse mid-frame with a different geometry must be ignored.
          bus3.start = bogus && (cyc == 5);
          bus3.iw = (bogus && cyc == 5) ? 16'd3 : 16'(w);
          bus3.ih = (bogus && cyc == 5) ? 16'd2 : 16'(h);
          if (idx < w * h) begin
            bus3.din = img[idx / w][idx % w];
            bus3.din_valid = ($urandom_range(0, 99) < duty);
          end else begin
            bus3.din_valid = 1'b0;
          end
        end
        bus3.din_valid = 1'b0;
        bus3.start = 1'b0;
        if (!abort_flag) check("d3_feed_done", 128'(idx), 128'(w * h));
      end
      if (abort) begin
        i = 0;
        while (i < 2000 && !(bus3.valid && bus3.sent_line_cntr == 16'd1)) begin
          @(negedge clk);
          i++;
        end
        check("t5_row1_seen", 128'(i < 2000), 128'(1));
        rstb = 1'b1;
        @(posedge clk); #1;
        rstb = 1'b0;
        check("t5_valid", 128'(bus3.valid), 128'(0));
        check("t5_din_ready", 128'(bus3.din_ready), 128'(0));
        check("t5_busy", 128'(bus3.busy), 128'(0));
        check("t5_done", 128'(bus3.frame_done), 128'(0));
        sb3.delete();
        abort_flag = 1'b1;
      end
    join
    if (abort) begin
      repeat (20) @(posedge clk);
      check("t5_no_frame_done", 128'(done3_cnt - done0), 128'(0));
    end else begin
      i = 0;
      while (i < 5000 && done3_cnt == done0) begin
        @(negedge clk);
        i++;
      end
      repeat (5) @(posedge clk);
      check("d3_done_once", 128'(done3_cnt - done0), 128'(1));
      check("d3_sb_drained", 128'(sb3.size()), 128'(0));
      check("d3_valid_count", 128'(v3_cnt), 128'(w * h));
      check("d3_busy_after", 128'(bus3.busy), 128'(0));
    end
  endtask

  task automatic check_t1();
    check("t1_r0c2", cap_a, 128'({14'd0, 14'd2, 14'd18}));
    check("t1_r1c0", cap_b, 128'({14'd0, 14'd16, 14'd32}));
    check("t1_r2c3", cap_c, 128'({14'd19, 14'd35, 14'd0}));
  endtask

  task automatic idle_bogus(input int w, input int h);
    @(posedge clk); #1;
    bus3.iw = 16'(w); bus3.ih = 16'(h); bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_busy", 128'(bus3.busy), 128'(0));
  endtask

  task automatic run5(input int w, input int h);
    int idx, cyc, i, done0;
    exp_t e;
    @(posedge clk); #1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y][x] = 14'(16 * y + x);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        e.r = 16'(r); e.c = 16'(c); e.stk = exp_stack(5, r, c, h);
        sb5.push_back(e);
      end
    v5_cnt = 0; cap5 = '1; done0 = done5_cnt;
    bus5.iw = 16'(w); bus5.ih = 16'(h); bus5.start = 1'b1;
    @(posedge clk); #1;
    bus5.start = 1'b0;
    idx = 0; cyc = 0;
    bus5.din = img[0][0];
    bus5.din_valid = 1'b1;
    while (idx < w * h && cyc < 20000) begin
      @(negedge clk);
      if (bus5.din_valid && bus5.din_ready) idx++;
      @(posedge clk); #1;
      cyc++;
      if (idx < w * h) bus5.din = img[idx / w][idx % w];
      else bus5.din_valid = 1'b0;
    end
    bus5.din_valid = 1'b0;
    i = 0;
    while (i < 5000 && done5_cnt == done0) begin
      @(negedge clk);
      i++;
    end
    repeat (5) @(posedge clk);
    check("d5_done_once", 128'(done5_cnt - done0), 128'(1));
    check("d5_sb_drained", 128'(sb5.size()), 128'(0));
    check("d5_valid_count", 128'(v5_cnt), 128'(w * h));
    check("t4_r2c2", cap5, 128'({14'd2, 14'd18, 14'd34, 14'd50, 14'd66}));
  endtask

  initial begin
    bus3.start = 1'b0; bus3.iw = '0; bus3.ih = '0; bus3.din = '0; bus3.din_valid = 1'b0;
    bus5.start = 1'b0; bus5.iw = '0; bus5.ih = '0; bus5.din = '0; bus5.din_valid = 1'b0;
    rstb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b0;
    check("rst_valid", 128'(bus3.valid), 128'(0));
    check("rst_din_ready", 128'(bus3.din_ready), 128'(0));
    check("rst_busy", 128'(bus3.busy), 128'(0));
    check("rst_frame_done", 128'(bus3.frame_done), 128'(0));
    check("rst_stack", 128'(bus3.stack_data), 128'(0));
    check("rst_line", 128'(bus3.sent_line_cntr), 128'(0));
    check("rst_pix", 128'(bus3.sent_pix_cntr), 128'(0));

    // Small frame with continuous input.
    run3(4, 3, 100, 1'b0, 1'b0, 1'b0);
    check_t1();

    // Wider frame, random pixels, plus a start pulse while busy.
    run3(16, 8, 100, 1'b1, 1'b0, 1'b1);
    check("t2_stalled", 128'(stall3 > 0), 128'(1));
    check("t2_lead_bound", 128'(max_lead <= 3), 128'(1));

    // Sparse input.
    run3(7, 6, 30, 1'b1, 1'b0, 1'b0);

    // Illegal geometry while idle.
    idle_bogus(0, 3);
    idle_bogus(1025, 3);
    idle_bogus(4, 0);

    // Abort mid-row-1, then a clean rerun of the small frame.
    run3(4, 3, 100, 1'b0, 1'b1, 1'b0);
    run3(4, 3, 100, 1'b0, 1'b0, 1'b0);
    check_t1();

    run5(5, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
